// File: rtl/colour_pkg.sv
// ============================================================================
// Module : colour_pkg
// Brief  : ASCII command constants, report state encoding and nibble encoder
//          shared by the colour command decoder and the colour reporter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package colour_pkg;

  localparam int MSG_LEN = 20;

  localparam logic [7:0] CH_R     = 8'h72;
  localparam logic [7:0] CH_G     = 8'h67;
  localparam logic [7:0] CH_B     = 8'h62;
  localparam logic [7:0] CMP_W    = 8'h77;
  localparam logic [7:0] CMP_B    = 8'h62;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Decoder power-on colours; the reporter's snapshot starts here too.
  localparam logic [11:0] WF_RESET = 12'h0FF;
  localparam logic [11:0] BG_RESET = 12'h000;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } rep_state_t;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

`default_nettype wire

// File: rtl/colour_reporter_if.sv
// ============================================================================
// Module : colour_reporter_if
// Brief  : Byte-stream UART TX handshake between colour reporter and UART.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface colour_reporter_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

`default_nettype wire

// File: rtl/colour_reporter.sv
// ============================================================================
// Module : colour_reporter
// Brief  : Serialises snapshotted waveform/background colours as decoder
//          command text ("rXw gXw bXw rXb gXb bXb CR LF") over a TX stream.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module colour_reporter #(
  parameter bit AUTO_ON_CHANGE = 1'b1,
  parameter int MSG_LEN        = 20
) (
  input  wire logic         clk,
  input  wire logic         resetn,
  input  wire logic [11:0]  waveform_colour,
  input  wire logic [11:0]  background_colour,
  input  wire logic         report_req,
  colour_reporter_if.master tx,
  output logic              busy
);
  import colour_pkg::*;

  // Trailer is CR then LF; its last position follows from the message length.
  localparam logic [1:0] c_LAST_TRAILER_POS = 2'(MSG_LEN - 19);

  rep_state_t  r_state,     w_state_nxt;
  logic [2:0]  r_group,     w_group_nxt,   w_group_adv;
  logic [1:0]  r_pos,       w_pos_nxt,     w_pos_adv;
  logic        r_trailer,   w_trailer_nxt, w_trailer_adv;
  logic [11:0] r_wf_snap,   w_wf_nxt;
  logic [11:0] r_bg_snap,   w_bg_nxt;
  logic        r_pending,   w_pending_nxt;
  logic [7:0]  r_tx_data,   w_tx_data_nxt;
  logic        w_change, w_accept, w_last;

  function automatic logic [7:0] select_byte(
    input logic [2:0]  group,
    input logic [1:0]  pos,
    input logic        trailer,
    input logic [11:0] wf,
    input logic [11:0] bg
  );
    logic [7:0] ch;
    logic [3:0] nib;
    case (group)
      3'd0, 3'd3: ch = CH_R;
      3'd1, 3'd4: ch = CH_G;
      default:    ch = CH_B;
    endcase
    case (group)
      3'd0:    nib = wf[3:0];
      3'd1:    nib = wf[7:4];
      3'd2:    nib = wf[11:8];
      3'd3:    nib = bg[3:0];
      3'd4:    nib = bg[7:4];
      default: nib = bg[11:8];
    endcase
    if (trailer)
      return (pos == 2'd0) ? ASCII_CR : ASCII_LF;
    case (pos)
      2'd0:    return ch;
      2'd1:    return nibble_to_ascii(nib);
      default: return (group < 3'd3) ? CMP_W : CMP_B;
    endcase
  endfunction

  assign w_change = AUTO_ON_CHANGE &&
                    ({waveform_colour, background_colour} != {r_wf_snap, r_bg_snap});
  assign w_accept = (r_state == ST_SEND) && tx.tx_ready;
  assign w_last   = r_trailer && (r_pos == c_LAST_TRAILER_POS);

  always_comb begin
    w_group_adv   = r_group;
    w_pos_adv     = r_pos + 2'd1;
    w_trailer_adv = r_trailer;
    if (!r_trailer && (r_pos == 2'd2)) begin
      w_pos_adv = 2'd0;
      if (r_group == 3'd5) begin
        w_group_adv   = 3'd0;
        w_trailer_adv = 1'b1;
      end else begin
        w_group_adv = r_group + 3'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_group_nxt   = r_group;
    w_pos_nxt     = r_pos;
    w_trailer_nxt = r_trailer;
    w_wf_nxt      = r_wf_snap;
    w_bg_nxt      = r_bg_snap;
    w_pending_nxt = r_pending;
    w_tx_data_nxt = r_tx_data;
    case (r_state)
      ST_IDLE: begin
        if (report_req || w_change) begin
          w_state_nxt   = ST_SEND;
          w_wf_nxt      = waveform_colour;
          w_bg_nxt      = background_colour;
          w_group_nxt   = 3'd0;
          w_pos_nxt     = 2'd0;
          w_trailer_nxt = 1'b0;
          w_pending_nxt = 1'b0;
          w_tx_data_nxt = select_byte(3'd0, 2'd0, 1'b0, waveform_colour, background_colour);
        end
      end
      default: begin
        if (report_req && !(w_accept && w_last))
          w_pending_nxt = 1'b1;
        if (w_accept) begin
          if (w_last) begin
            w_group_nxt   = 3'd0;
            w_pos_nxt     = 2'd0;
            w_trailer_nxt = 1'b0;
            if (r_pending || report_req || w_change) begin
              // Back-to-back restart: tx_valid stays high, no idle cycle.
              w_wf_nxt      = waveform_colour;
              w_bg_nxt      = background_colour;
              w_pending_nxt = 1'b0;
              w_tx_data_nxt = select_byte(3'd0, 2'd0, 1'b0, waveform_colour, background_colour);
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_group_nxt   = w_group_adv;
            w_pos_nxt     = w_pos_adv;
            w_trailer_nxt = w_trailer_adv;
            w_tx_data_nxt = select_byte(w_group_adv, w_pos_adv, w_trailer_adv,
                                        r_wf_snap, r_bg_snap);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_group   <= 3'd0;
      r_pos     <= 2'd0;
      r_trailer <= 1'b0;
      r_wf_snap <= WF_RESET;
      r_bg_snap <= BG_RESET;
      r_pending <= 1'b0;
      r_tx_data <= 8'h00;
    end else begin
      r_state   <= w_state_nxt;
      r_group   <= w_group_nxt;
      r_pos     <= w_pos_nxt;
      r_trailer <= w_trailer_nxt;
      r_wf_snap <= w_wf_nxt;
      r_bg_snap <= w_bg_nxt;
      r_pending <= w_pending_nxt;
      r_tx_data <= w_tx_data_nxt;
    end
  end

  assign tx.tx_data  = r_tx_data;
  assign tx.tx_valid = (r_state == ST_SEND);
  assign busy        = (r_state == ST_SEND);

endmodule

`default_nettype wire

// File: tb/tb_colour_reporter.sv
// ============================================================================
// Module : tb_colour_reporter
// Brief  : Scoreboard bench for colour_reporter; expected bytes are queued by
//          the stimulus and popped by a monitor on each TX handshake.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_colour_reporter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [11:0] wf = 12'h0FF;
  logic [11:0] bg = 12'h000;
  logic        report_req = 1'b0;
  logic        busy;
  logic        rand_ready = 1'b0;

  colour_reporter_if tx_if ();

  colour_reporter #(
    .AUTO_ON_CHANGE (1'b1),
    .MSG_LEN        (20)
  ) dut (
    .clk               (clk),
    .resetn            (resetn),
    .waveform_colour   (wf),
    .background_colour (bg),
    .report_req        (report_req),
    .tx                (tx_if.master),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    tx_if.tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  int         n_checks = 0;
  int         n_fail = 0;
  int         n_accepted = 0;
  int         busy_cycles = 0;
  logic [7:0] exp_q[$];
  logic       hold_pending = 1'b0;
  logic [7:0] held_data = 8'h00;
  logic [7:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: stability while stalled, then one scoreboard pop per handshake.
  always @(negedge clk) begin
    if (!resetn) begin
      hold_pending = 1'b0;
    end else begin
      if (busy) busy_cycles++;
      if (hold_pending) begin
        check("hold_valid", {31'd0, tx_if.tx_valid}, 32'd1);
        check("hold_data", {24'd0, tx_if.tx_data}, {24'd0, held_data});
      end
      if (tx_if.tx_valid && tx_if.tx_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_byte: got 0x%0h, expected no transfer", tx_if.tx_data);
        end else begin
          mon_exp = exp_q.pop_front();
          check("tx_byte", {24'd0, tx_if.tx_data}, {24'd0, mon_exp});
        end
        n_accepted++;
      end
      hold_pending = tx_if.tx_valid && !tx_if.tx_ready;
      held_data    = tx_if.tx_data;
    end
  end

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_req();
    @(posedge clk); #1;
    report_req = 1'b1;
    @(posedge clk); #1;
    report_req = 1'b0;
    check("req_valid", {31'd0, tx_if.tx_valid}, 32'd1);
    check("req_busy", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d bytes outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    step(1);
    check("busy_after_report", {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_accepts(input int target, input int budget);
    int k = 0;
    while (n_accepted < target && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    if (n_accepted < target) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got %0d bytes, expected %0d", n_accepted, target);
    end
  endtask

  task automatic expect_quiet(input int n);
    int v = 0;
    repeat (n) begin
      @(negedge clk);
      if (tx_if.tx_valid) v++;
    end
    check("quiet_cycles_valid", v, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    // Reset state and no auto report with the decoder's reset colours.
    step(3);
    check("rst_valid", {31'd0, tx_if.tx_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_data", {24'd0, tx_if.tx_data}, 32'h00);
    resetn = 1'b1;
    expect_quiet(5);

    // Requested report of the reset colours, tx_ready held high.
    base = busy_cycles;
    push_str("rFwgFwb0wr0bg0bb0b\r\n");
    pulse_req();
    wait_drain(100);
    check("busy_cycles_single", busy_cycles - base, 20);

    // Auto report on change, with a random tx_ready pattern.
    rand_ready = 1'b1;
    push_str("rCwg5wbAwr1bgEbb3b\r\n");
    @(posedge clk); #1;
    wf = 12'hA5C;
    bg = 12'h3E1;
    step(1);
    check("auto_latency_valid", {31'd0, tx_if.tx_valid}, 32'd1);
    wait_drain(400);
    rand_ready = 1'b0;
    step(1);

    // Input change mid-report: old snapshot first, then a gapless new report.
    base = busy_cycles;
    push_str("rFwgFwb0wr0bg0bb0b\r\n");
    push_str("r3wg2wb1wr0bg0bb0b\r\n");
    @(posedge clk); #1;
    wf = 12'h0FF;
    bg = 12'h000;
    wait_accepts(n_accepted + 5, 50);
    wf = 12'h123;
    wait_drain(100);
    check("busy_cycles_change", busy_cycles - base, 40);

    // Two requests during a report coalesce into exactly one extra report.
    base = busy_cycles;
    push_str("r3wg2wb1wr0bg0bb0b\r\n");
    push_str("r3wg2wb1wr0bg0bb0b\r\n");
    pulse_req();
    step(3);
    pulse_req();
    step(2);
    pulse_req();
    wait_drain(100);
    check("busy_cycles_coalesce", busy_cycles - base, 40);
    expect_quiet(5);

    // Reset in the middle of a report.
    push_str("r3wg2wb1wr0bg0bb0b\r\n");
    pulse_req();
    wait_accepts(n_accepted + 9, 50);
    resetn = 1'b0;
    wf = 12'h0FF;
    bg = 12'h000;
    exp_q.delete();
    step(1);
    check("midrst_valid", {31'd0, tx_if.tx_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_data", {24'd0, tx_if.tx_data}, 32'h00);
    step(1);
    resetn = 1'b1;
    expect_quiet(8);

    // Recovery: a fresh request reports the reset colours again.
    push_str("rFwgFwb0wr0bg0bb0b\r\n");
    pulse_req();
    wait_drain(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
